// File: rtl/centroid_accumulator.sv
// Frame centroid engine: accumulates masked pixel coordinates, then drives a shared
// iterative divider twice (x_sum/count, y_sum/count) and reports the integer centroid.
module centroid_accumulator #(
  parameter int unsigned H_WIDTH   = 11,
  parameter int unsigned V_WIDTH   = 10,
  parameter int unsigned SUM_WIDTH = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [H_WIDTH-1:0]   x_in,
  input  logic [V_WIDTH-1:0]   y_in,
  input  logic                 valid_in,
  input  logic                 tabulate_in,
  output logic [SUM_WIDTH-1:0] dividend_out,
  output logic [SUM_WIDTH-1:0] divisor_out,
  output logic                 div_valid_out,
  input  logic [SUM_WIDTH-1:0] quotient_in,
  input  logic                 div_valid_in,
  output logic [H_WIDTH-1:0]   x_out,
  output logic [V_WIDTH-1:0]   y_out,
  output logic                 empty_out,
  output logic                 valid_out,
  output logic                 busy_out,
  output logic                 overrun_out
);

  typedef enum logic [2:0] {
    StIdle,
    StLaunchX,
    StWaitX,
    StLaunchY,
    StWaitY,
    StDone
  } state_e;

  localparam logic [SUM_WIDTH-1:0] One = 1;

  state_e               state_q;
  logic [SUM_WIDTH-1:0] x_sum_q, y_sum_q, count_q;
  logic [SUM_WIDTH-1:0] y_snap_q, count_snap_q;
  logic [H_WIDTH-1:0]   x_res_q;
  logic [SUM_WIDTH-1:0] x_ext, y_ext;
  logic                 unused_quotient_bits;

  assign x_ext    = {{(SUM_WIDTH - H_WIDTH){1'b0}}, x_in};
  assign y_ext    = {{(SUM_WIDTH - V_WIDTH){1'b0}}, y_in};
  assign busy_out = (state_q != StIdle);

  // Only the low H_WIDTH quotient bits can carry a coordinate.
  assign unused_quotient_bits = ^quotient_in[SUM_WIDTH-1:H_WIDTH];

  // A pixel arriving with tabulate_in starts the next frame.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      x_sum_q <= '0;
      y_sum_q <= '0;
      count_q <= '0;
    end else if (tabulate_in) begin
      x_sum_q <= valid_in ? x_ext : '0;
      y_sum_q <= valid_in ? y_ext : '0;
      count_q <= valid_in ? One : '0;
    end else if (valid_in) begin
      x_sum_q <= x_sum_q + x_ext;
      y_sum_q <= y_sum_q + y_ext;
      count_q <= count_q + One;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q       <= StIdle;
      y_snap_q      <= '0;
      count_snap_q  <= '0;
      x_res_q       <= '0;
      dividend_out  <= '0;
      divisor_out   <= '0;
      div_valid_out <= 1'b0;
      x_out         <= '0;
      y_out         <= '0;
      empty_out     <= 1'b0;
      valid_out     <= 1'b0;
      overrun_out   <= 1'b0;
    end else begin
      div_valid_out <= 1'b0;
      valid_out     <= 1'b0;
      overrun_out   <= tabulate_in && (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (tabulate_in) begin
            // dividend_out doubles as the x snapshot; the request is pre-armed so
            // div_valid_out is high during LAUNCH_X itself.
            y_snap_q      <= y_sum_q;
            count_snap_q  <= count_q;
            dividend_out  <= x_sum_q;
            divisor_out   <= count_q;
            div_valid_out <= (count_q != '0);
            state_q       <= StLaunchX;
          end
        end
        StLaunchX: begin
          if (count_snap_q == '0) begin
            empty_out <= 1'b1;
            valid_out <= 1'b1;
            state_q   <= StDone;
          end else begin
            state_q <= StWaitX;
          end
        end
        StWaitX: begin
          if (div_valid_in) begin
            x_res_q       <= quotient_in[H_WIDTH-1:0];
            dividend_out  <= y_snap_q;
            div_valid_out <= 1'b1;
            state_q       <= StLaunchY;
          end
        end
        StLaunchY: begin
          state_q <= StWaitY;
        end
        StWaitY: begin
          if (div_valid_in) begin
            x_out     <= x_res_q;
            y_out     <= quotient_in[V_WIDTH-1:0];
            empty_out <= 1'b0;
            valid_out <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_accumulator.sv
// Directed bench for centroid_accumulator with a fixed-latency behavioural divider.
module tb_centroid_accumulator;
  localparam int HW = 11;
  localparam int VW = 10;
  localparam int SW = 32;
  localparam int DIV_LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [HW-1:0] x_in;
  logic [VW-1:0] y_in;
  logic          valid_in, tabulate_in;
  logic [SW-1:0] dividend_out, divisor_out, quotient_in;
  logic          div_valid_out, div_valid_in;
  logic [HW-1:0] x_out;
  logic [VW-1:0] y_out;
  logic          empty_out, valid_out, busy_out, overrun_out;

  centroid_accumulator #(.H_WIDTH(HW), .V_WIDTH(VW), .SUM_WIDTH(SW)) dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .x_in         (x_in),
    .y_in         (y_in),
    .valid_in     (valid_in),
    .tabulate_in  (tabulate_in),
    .dividend_out (dividend_out),
    .divisor_out  (divisor_out),
    .div_valid_out(div_valid_out),
    .quotient_in  (quotient_in),
    .div_valid_in (div_valid_in),
    .x_out        (x_out),
    .y_out        (y_out),
    .empty_out    (empty_out),
    .valid_out    (valid_out),
    .busy_out     (busy_out),
    .overrun_out  (overrun_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: answers DIV_LAT+1 cycles after a request, ignores reset.
  logic [SW-1:0] m_a = '0, m_b = '0, m_q = '0;
  logic          m_vld = 1'b0;
  int            tmr = 0;
  logic          spur_vld = 1'b0;
  logic [SW-1:0] spur_q = '0;

  always @(posedge clk) begin
    m_vld <= 1'b0;
    if (div_valid_out) begin
      m_a <= dividend_out;
      m_b <= divisor_out;
      tmr <= DIV_LAT;
    end else if (tmr != 0) begin
      tmr <= tmr - 1;
      if (tmr == 1) begin
        m_vld <= 1'b1;
        m_q   <= (m_b == '0) ? '0 : m_a / m_b;
      end
    end
  end

  assign div_valid_in = m_vld | spur_vld;
  assign quotient_in  = spur_vld ? spur_q : m_q;

  // Monitor samples just after each rising edge.
  logic [SW-1:0] req_dvd[$];
  logic [SW-1:0] req_dvs[$];
  int            vcnt = 0, ocnt = 0, vcyc = 0;
  logic [HW-1:0] vx = '0;
  logic [VW-1:0] vy = '0;
  logic          ve = 1'b0;

  always @(posedge clk) begin
    #1;
    if (div_valid_out) begin
      req_dvd.push_back(dividend_out);
      req_dvs.push_back(divisor_out);
    end
    if (valid_out) begin
      vcnt <= vcnt + 1;
      vx   <= x_out;
      vy   <= y_out;
      ve   <= empty_out;
      vcyc <= cyc;
    end
    if (overrun_out) ocnt <= ocnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic pix(input int x, input int y);
    x_in     = x[HW-1:0];
    y_in     = y[VW-1:0];
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic tab(input bit pv, input int x, input int y);
    x_in        = x[HW-1:0];
    y_in        = y[VW-1:0];
    valid_in    = pv;
    tabulate_in = 1'b1;
    @(negedge clk);
    tabulate_in = 1'b0;
    valid_in    = 1'b0;
  endtask

  // Waits (bounded) for one result, then checks it and the divider requests it made.
  task automatic expect_frame(input string tag, input int vb, input int rb, input int nreq,
                              input int ex, input int ey, input int ee,
                              input int d0, input int s0, input int d1, input int s1);
    int n = 0;
    while (vcnt == vb && n < 80) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_seen"}, 32'(vcnt != vb), 1);
    check({tag, "_x"}, 32'(vx), ex);
    check({tag, "_y"}, 32'(vy), ey);
    check({tag, "_empty"}, 32'(ve), ee);
    repeat (5) @(negedge clk);
    check({tag, "_once"}, vcnt, vb + 1);
    check({tag, "_nreq"}, req_dvd.size(), rb + nreq);
    check({tag, "_idle"}, 32'(busy_out), 0);
    if (nreq == 2 && req_dvd.size() >= rb + 2) begin
      check({tag, "_dvd_x"}, req_dvd[rb], d0);
      check({tag, "_dvs_x"}, req_dvs[rb], s0);
      check({tag, "_dvd_y"}, req_dvd[rb+1], d1);
      check({tag, "_dvs_y"}, req_dvs[rb+1], s1);
    end
  endtask

  initial begin
    int vb, rb, ob, t0;
    rst_n = 1'b0;
    x_in = '0; y_in = '0; valid_in = 1'b0; tabulate_in = 1'b0;

    // Reset held while inputs toggle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x_in        = HW'($urandom);
      y_in        = VW'($urandom);
      valid_in    = 1'($urandom_range(0, 1));
      tabulate_in = 1'b1;
    end
    @(negedge clk);
    check("rst_x", 32'(x_out), 0);
    check("rst_y", 32'(y_out), 0);
    check("rst_empty", 32'(empty_out), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_divvalid", 32'(div_valid_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    check("rst_overrun", 32'(overrun_out), 0);
    check("rst_dividend", dividend_out, 0);
    check("rst_divisor", divisor_out, 0);
    x_in = '0; y_in = '0; valid_in = 1'b0; tabulate_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic three-pixel frame
    vb = vcnt; rb = req_dvd.size();
    pix(10, 20); pix(30, 40); pix(50, 60);
    tab(0, 0, 0);
    expect_frame("f3", vb, rb, 2, 30, 40, 0, 90, 3, 120, 3);

    // Truncating division
    vb = vcnt; rb = req_dvd.size();
    pix(1, 0); pix(2, 0);
    tab(0, 0, 0);
    expect_frame("trunc", vb, rb, 2, 1, 0, 0, 3, 2, 0, 2);

    // Empty frame: no request, result after exactly 2 cycles, old coordinates held
    vb = vcnt; rb = req_dvd.size();
    t0 = cyc;
    tab(0, 0, 0);
    expect_frame("empty", vb, rb, 0, 1, 0, 1, 0, 0, 0, 0);
    check("empty_lat", vcyc - t0, 2);

    // Pixel coincident with tabulate belongs to the next frame
    vb = vcnt; rb = req_dvd.size();
    pix(5, 7); pix(7, 9);
    tab(1, 100, 100);
    expect_frame("coin_a", vb, rb, 2, 6, 8, 0, 12, 2, 16, 2);
    vb = vcnt; rb = req_dvd.size();
    tab(0, 0, 0);
    expect_frame("coin_b", vb, rb, 2, 100, 100, 0, 100, 1, 100, 1);

    // Overrun during WAIT_X
    vb = vcnt; rb = req_dvd.size(); ob = ocnt;
    pix(8, 4);
    tab(0, 0, 0);
    @(negedge clk);
    check("ovr_busy", 32'(busy_out), 1);
    tab(0, 0, 0);
    pix(20, 30);
    expect_frame("ovr_a", vb, rb, 2, 8, 4, 0, 8, 1, 4, 1);
    check("ovr_pulse", ocnt, ob + 1);
    vb = vcnt; rb = req_dvd.size();
    tab(0, 0, 0);
    expect_frame("ovr_b", vb, rb, 2, 20, 30, 0, 20, 1, 30, 1);

    // Spurious divider response in IDLE
    vb = vcnt;
    spur_q   = 32'd55;
    spur_vld = 1'b1;
    @(negedge clk);
    spur_vld = 1'b0;
    repeat (10) @(negedge clk);
    check("spur_novalid", vcnt, vb);
    check("spur_x", 32'(x_out), 20);
    check("spur_busy", 32'(busy_out), 0);

    // Reset mid-sequence; the late divider answer must be ignored
    vb = vcnt;
    pix(9, 9);
    tab(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy_out), 0);
    check("midrst_x", 32'(x_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_novalid", vcnt, vb);
    check("midrst_idle", 32'(busy_out), 0);
    check("midrst_y", 32'(y_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/centroid_accumulator.md
Name: centroid_accumulator

Overview:
- Sits directly upstream of the iterative `divider` (WIDTH = SUM_WIDTH).
- Accumulates x-sum, y-sum and pixel count of mask-valid pixels over one frame.
- On a frame-end pulse, snapshots the totals and issues two serialized divide requests (x_sum/count, then y_sum/count) to a single shared divider.
- Presents the integer centroid (x, y) with a one-cycle valid pulse to the overlay/tracking logic.

Parameters:
- H_WIDTH, 11, bit width of pixel x coordinate (1024 columns).
- V_WIDTH, 10, bit width of pixel y coordinate (768 rows).
- SUM_WIDTH, 32, width of accumulators, snapshot registers and the divider data path.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- x_in  input  H_WIDTH  pixel column
- y_in  input  V_WIDTH  pixel row
- valid_in  input  1  pixel is in mask; accumulate this cycle
- tabulate_in  input  1  frame-end pulse; start centroid computation
- dividend_out  output  SUM_WIDTH  to divider dividend_in
- divisor_out  output  SUM_WIDTH  to divider divisor_in
- div_valid_out  output  1  to divider data_valid_in; one-cycle pulse
- quotient_in  input  SUM_WIDTH  from divider quotient_out
- div_valid_in  input  1  from divider data_valid_out
- x_out  output  H_WIDTH  centroid column
- y_out  output  V_WIDTH  centroid row
- empty_out  output  1  last tabulated frame had zero pixels
- valid_out  output  1  one-cycle pulse; x_out/y_out/empty_out updated
- busy_out  output  1  division sequence in progress
- overrun_out  output  1  one-cycle pulse; tabulate_in arrived while busy

Behaviour:
- Reset (rst_in == 0 at a clk_in edge):
  - accumulators, snapshots, x_out, y_out, dividend_out and divisor_out clear to 0.
  - empty_out, valid_out, div_valid_out, busy_out and overrun_out clear to 0.
  - FSM goes to IDLE.
  - Reset mid-sequence abandons the sequence; a late div_valid_in is ignored because the FSM is in IDLE.
- Accumulation runs every cycle, independent of FSM state:
  - valid_in = 1 -> x_sum += x_in, y_sum += y_in, count += 1.
  - Zero-extend all operands to SUM_WIDTH.
  - With the defaults nothing can overflow (max x_sum < 2^30), so no saturation is required.
- tabulate_in = 1:
  - Accumulators reload for the new frame: to the current pixel if valid_in = 1 in the same cycle, otherwise to 0. A simultaneous pixel belongs to the new frame.
  - If the FSM is in IDLE: copy the pre-update sums and count into snapshot registers and go to LAUNCH_X.
  - If the FSM is not in IDLE: accumulators still reload, snapshots are untouched, the sequence continues, and overrun_out pulses for one cycle.
- FSM states: IDLE, LAUNCH_X, WAIT_X, LAUNCH_Y, WAIT_Y, DONE. busy_out = 1 in every state except IDLE.
- IDLE -> LAUNCH_X on tabulate_in.
- LAUNCH_X:
  - If snapshot count == 0: go to DONE with empty flag set and no divider request.
  - Otherwise: dividend_out = x snapshot, divisor_out = count snapshot, div_valid_out = 1 for exactly this cycle, then go to WAIT_X.
- WAIT_X: hold dividend_out/divisor_out stable. On div_valid_in, latch quotient_in[H_WIDTH-1:0] into the x result register and go to LAUNCH_Y.
- LAUNCH_Y: same as LAUNCH_X with the y snapshot; div_valid_out pulses once, then go to WAIT_Y.
- WAIT_Y: on div_valid_in, latch quotient_in[V_WIDTH-1:0] and go to DONE.
- DONE (one cycle):
  - Non-empty frame: drive x_out/y_out from the result registers and set empty_out = 0.
  - Empty frame: x_out/y_out hold their previous values and empty_out = 1.
  - valid_out = 1 this cycle; next state is IDLE.
- div_valid_in in IDLE, LAUNCH_X, LAUNCH_Y or DONE: ignored.
- The divider has no backpressure; at most one request is outstanding at a time.
- Latency from tabulate_in to valid_out = 2 + divider latency × 2 + 2 cycles. The count-zero path takes exactly 2 cycles.
- x_out, y_out and empty_out hold between valid_out pulses.

Test Plan:
- Reset with inputs toggling -> all outputs 0, busy_out = 0. Hold reset during an active sequence -> returns to IDLE and no valid_out follows.
- Pixels (10,20), (30,40), (50,60) then tabulate_in:
  - divider sees 90/3, then 120/3, each div_valid_out exactly one cycle.
  - valid_out pulses once with x_out = 30, y_out = 40, empty_out = 0.
- Truncation: pixels (1,0), (2,0) -> x_out = 1 (3/2), y_out = 0.
- tabulate_in with zero pixels:
  - no div_valid_out; valid_out exactly 2 cycles later.
  - empty_out = 1; x_out/y_out unchanged from the previous frame.
- tabulate_in with valid_in = 1 at (100,100) in the same cycle:
  - the current division uses only the earlier pixels.
  - the next frame's tabulate (no other pixels) yields (100,100).
- Second tabulate_in during WAIT_X:
  - overrun_out pulses; the first result (pixel (8,4) -> 8,4) completes unchanged.
  - pixels accumulated after the overrun appear on the following tabulate.
  - a spurious div_valid_in in IDLE causes no valid_out.
